// File: rtl/fa_pkg.sv
// Shared constants for the FA-rate um interlock: default widths and FSM encoding.
package fa_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;
    localparam logic [1:0] ST_TRIPPED = 2'd3;
endpackage

// File: rtl/fa_um_intlk_if.sv
// Sample/control/status bundle between the um integrator side and the interlock.
interface fa_um_intlk_if
    import fa_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic                     clk_enable;
    logic signed [DATA_W-1:0] x_um_i;
    logic signed [DATA_W-1:0] limit_hi;
    logic signed [DATA_W-1:0] limit_lo;
    logic        [CNT_W-1:0]  persist_n;
    logic                     arm;
    logic                     clear;
    logic                     ce_out;
    logic                     trip_o;
    logic signed [DATA_W-1:0] trip_val_o;
    logic        [CNT_W-1:0]  run_cnt_o;
    logic        [CNT_W-1:0]  trip_cnt_o;
    logic        [1:0]        state_o;

    modport master (
        output clk_enable, x_um_i, limit_hi, limit_lo, persist_n, arm, clear,
        input  ce_out, trip_o, trip_val_o, run_cnt_o, trip_cnt_o, state_o
    );

    modport slave (
        input  clk_enable, x_um_i, limit_hi, limit_lo, persist_n, arm, clear,
        output ce_out, trip_o, trip_val_o, run_cnt_o, trip_cnt_o, state_o
    );
endinterface

// File: rtl/fa_win_cmp.sv
// Signed window comparator; an inverted window (lo > hi) flags every sample.
module fa_win_cmp #(
    parameter int W = 32
) (
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] hi,
    input  logic signed [W-1:0] lo,
    output logic                oow
);
    assign oow = (x > hi) || (x < lo);
endmodule

// File: rtl/fa_um_intlk.sv
// Position interlock: trips after pn consecutive out-of-window FA samples,
// latching the offending sample and counting trips until cleared.
module fa_um_intlk
    import fa_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    fa_um_intlk_if.slave      bus
);
    logic [1:0]               state;
    logic                     trip;
    logic signed [DATA_W-1:0] trip_val;
    logic [CNT_W-1:0]         run_cnt;
    logic [CNT_W-1:0]         trip_cnt;
    logic                     oow;
    logic                     hit;
    logic [CNT_W:0]           pn;
    logic [CNT_W:0]           run_nxt;

    fa_win_cmp #(.W(DATA_W)) u_cmp (
        .x   (bus.x_um_i),
        .hi  (bus.limit_hi),
        .lo  (bus.limit_lo),
        .oow (oow)
    );

    // persist_n = 0 is treated as 1; extra bit keeps run_cnt+1 from wrapping
    assign pn      = (bus.persist_n == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, bus.persist_n};
    assign run_nxt = {1'b0, run_cnt} + 1'b1;
    assign hit     = bus.clk_enable && oow;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            trip     <= 1'b0;
            trip_val <= '0;
            run_cnt  <= '0;
            trip_cnt <= '0;
        end else if (bus.clear) begin
            state   <= ST_IDLE;
            trip    <= 1'b0;
            run_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.arm) begin
                        state   <= ST_ARMED;
                        run_cnt <= '0;
                    end
                end
                ST_ARMED, ST_PENDING: begin
                    if (hit) begin
                        // ARMED has run_cnt = 0, so both states share the trip test
                        if (run_nxt >= pn) begin
                            state    <= ST_TRIPPED;
                            trip     <= 1'b1;
                            trip_val <= bus.x_um_i;
                            run_cnt  <= pn[CNT_W-1:0];
                            if (trip_cnt != '1)
                                trip_cnt <= trip_cnt + 1'b1;
                        end else begin
                            state   <= ST_PENDING;
                            run_cnt <= run_nxt[CNT_W-1:0];
                        end
                    end else if (bus.clk_enable) begin
                        state   <= ST_ARMED;
                        run_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ce_out     = bus.clk_enable;
    assign bus.trip_o     = trip;
    assign bus.trip_val_o = trip_val;
    assign bus.run_cnt_o  = run_cnt;
    assign bus.trip_cnt_o = trip_cnt;
    assign bus.state_o    = state;
endmodule

// File: tb/tb_fa_um_intlk.sv
// Scoreboard bench for fa_um_intlk: expected outputs queued per driven cycle.
module tb_fa_um_intlk;
    import fa_pkg::*;

    localparam int DW = 32;
    localparam int CW = 8;

    typedef struct {
        string                st_tag;
        logic [1:0]           st;
        logic                 trip;
        logic signed [DW-1:0] val;
        logic [CW-1:0]        run;
        logic [CW-1:0]        tcnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb[$];

    fa_um_intlk_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    fa_um_intlk #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    endtask

    // drive one cycle, queue its expected post-edge outputs, then compare
    task automatic step(input string tag, input logic ce, input int x, input logic a, input logic c,
                        input logic [1:0] es, input logic et, input int ev,
                        input int er, input int ec);
        exp_t e;
        exp_t g;
        @(negedge clk);
        bus.clk_enable = ce;
        bus.x_um_i     = x;
        bus.arm        = a;
        bus.clear      = c;
        e.st_tag = tag; e.st = es; e.trip = et; e.val = ev;
        e.run = er[CW-1:0]; e.tcnt = ec[CW-1:0];
        sb.push_back(e);
        #1;
        chk({tag, ".ce_out"}, {31'b0, bus.ce_out}, {31'b0, ce});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            chk({g.st_tag, ".state"}, {30'b0, bus.state_o}, {30'b0, g.st});
            chk({g.st_tag, ".trip"}, {31'b0, bus.trip_o}, {31'b0, g.trip});
            chk({g.st_tag, ".val"}, bus.trip_val_o, g.val);
            chk({g.st_tag, ".run"}, {24'b0, bus.run_cnt_o}, {24'b0, g.run});
            chk({g.st_tag, ".tcnt"}, {24'b0, bus.trip_cnt_o}, {24'b0, g.tcnt});
        end
        bus.arm   = 1'b0;
        bus.clear = 1'b0;
    endtask

    initial begin
        int tc;
        reset = 1'b1;
        bus.clk_enable = 1'b0; bus.x_um_i = 0; bus.arm = 1'b0; bus.clear = 1'b0;
        bus.limit_hi = 1000; bus.limit_lo = -1000; bus.persist_n = 3;
        step("rst", 0, 0, 0, 0, ST_IDLE, 0, 0, 0, 0);
        reset = 1'b0;

        step("idle_ign", 1, 5000, 0, 0, ST_IDLE, 0, 0, 0, 0);
        step("arm", 0, 0, 1, 0, ST_ARMED, 0, 0, 0, 0);
        step("in0", 1, 0, 0, 0, ST_ARMED, 0, 0, 0, 0);
        step("in500", 1, 500, 0, 0, ST_ARMED, 0, 0, 0, 0);
        step("in_hi", 1, 1000, 0, 0, ST_ARMED, 0, 0, 0, 0);
        step("in_lo", 1, -1000, 0, 0, ST_ARMED, 0, 0, 0, 0);
        step("noce", 0, 9999, 0, 0, ST_ARMED, 0, 0, 0, 0);

        step("o1001", 1, 1001, 0, 0, ST_PENDING, 0, 0, 1, 0);
        step("o1002", 1, 1002, 1, 0, ST_PENDING, 0, 0, 2, 0);
        for (int i = 0; i < 5; i++)
            step("gap", 0, 0, 0, 0, ST_PENDING, 0, 0, 2, 0);
        step("o1003", 1, 1003, 0, 0, ST_TRIPPED, 1, 1003, 3, 1);
        step("trp_hold", 1, 7777, 1, 0, ST_TRIPPED, 1, 1003, 3, 1);

        step("clr1", 0, 0, 0, 1, ST_IDLE, 0, 1003, 0, 1);
        step("arm2", 0, 0, 1, 0, ST_ARMED, 0, 1003, 0, 1);
        step("r2000a", 1, 2000, 0, 0, ST_PENDING, 0, 1003, 1, 1);
        step("r2000b", 1, 2000, 0, 0, ST_PENDING, 0, 1003, 2, 1);
        step("r0", 1, 0, 0, 0, ST_ARMED, 0, 1003, 0, 1);
        step("r2000c", 1, 2000, 0, 0, ST_PENDING, 0, 1003, 1, 1);

        // persist lowered mid-run: next oow trips, run_cnt reports pn
        bus.persist_n = 0;
        step("pn0_pend", 1, -5000, 0, 0, ST_TRIPPED, 1, -5000, 1, 2);
        step("clr_arm", 0, 0, 1, 1, ST_IDLE, 0, -5000, 0, 2);
        step("arm3", 0, 0, 1, 0, ST_ARMED, 0, -5000, 0, 2);
        step("pn0_arm", 1, -5001, 0, 0, ST_TRIPPED, 1, -5001, 1, 3);

        step("clr_inv", 0, 0, 0, 1, ST_IDLE, 0, -5001, 0, 3);
        bus.limit_lo = 10; bus.limit_hi = -10; bus.persist_n = 1;
        step("arm_inv", 0, 0, 1, 0, ST_ARMED, 0, -5001, 0, 3);
        step("inv0", 1, 0, 0, 0, ST_TRIPPED, 1, 0, 1, 4);
        tc = 4;
        for (int i = 0; i < 260; i++) begin
            step("sat_clr", 0, 0, 0, 1, ST_IDLE, 0, i, 0, tc);
            step("sat_arm", 0, 0, 1, 0, ST_ARMED, 0, i, 0, tc);
            if (tc < 255) tc++;
            step("sat_trip", 1, i + 1, 0, 0, ST_TRIPPED, 1, i + 1, 1, tc);
        end

        step("clr4", 0, 0, 0, 1, ST_IDLE, 0, 260, 0, 255);
        bus.limit_lo = -1000; bus.limit_hi = 1000; bus.persist_n = 3;
        step("arm4", 0, 0, 1, 0, ST_ARMED, 0, 260, 0, 255);
        step("p1", 1, 1001, 0, 0, ST_PENDING, 0, 260, 1, 255);
        step("p2", 1, -1001, 0, 0, ST_PENDING, 0, 260, 2, 255);
        reset = 1'b1;
        step("rst_pend", 1, 1001, 0, 0, ST_IDLE, 0, 0, 0, 0);
        reset = 1'b0;
        step("post_ign", 1, 1001, 0, 0, ST_IDLE, 0, 0, 0, 0);
        step("post_arm", 0, 0, 1, 0, ST_ARMED, 0, 0, 0, 0);

        if (sb.size() != 0) chk("sb_left", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fa_um_intlk.md
Name: fa_um_intlk

Overview:
- Downstream consumer of the nm-to-um conversion/integrator stage.
- Takes the filtered int32 um position and compares it, each FA sample, against a programmable signed window [limit_lo, limit_hi].
- Raises a latched interlock trip after persist_n consecutive out-of-window samples.
- Captures the triggering value, keeps a saturating trip count, and is armed and cleared by software pulses.

Parameters:
DATA_W, 32, width of position sample and limits (signed int32, um)
CNT_W, 16, width of persistence setting, run counter and trip counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clk_enable  in  1  FA sample strobe; a sample is consumed only on cycles where it is 1
x_um_i  in  DATA_W  signed filtered position (upstream x_um_filt_o)
limit_hi  in  DATA_W  signed upper window limit
limit_lo  in  DATA_W  signed lower window limit
persist_n  in  CNT_W  unsigned consecutive out-of-window samples required to trip
arm  in  1  single-cycle pulse; enables checking
clear  in  1  single-cycle pulse; drops trip, disarms
ce_out  out  1  equals clk_enable, combinational
trip_o  out  1  latched interlock trip
trip_val_o  out  DATA_W  signed sample that caused the trip
run_cnt_o  out  CNT_W  current consecutive out-of-window count
trip_cnt_o  out  CNT_W  number of trips since reset, saturating
state_o  out  2  FSM state: 0 IDLE, 1 ARMED, 2 PENDING, 3 TRIPPED

Behaviour:
- Reset (synchronous, active-high): state IDLE; trip_o, trip_val_o, run_cnt_o and trip_cnt_o are all 0. Reset mid-PENDING or mid-TRIPPED discards everything, including trip_cnt.
- Out-of-window test:
  - oow = (x_um_i > limit_hi) or (x_um_i < limit_lo), full signed compare, strict inequality; a sample equal to a limit is in-window.
  - If limit_lo > limit_hi, every sample is out-of-window.
- Limits and persist_n are sampled in the same cycle as x_um_i. No internal shadowing.
- Effective persistence pn = max(persist_n, 1); persist_n = 0 behaves as 1.
- All outputs are registered. trip_o rises on the clock edge that consumes the pn-th consecutive oow sample, i.e. 1 cycle latency from sample presentation.
- Priority within a cycle: clear > arm > sample processing.
- clear (any state) -> IDLE; trip_o = 0; run_cnt = 0; trip_val_o holds its last value; trip_cnt is unchanged. arm in the same cycle is ignored.
- IDLE: arm -> ARMED; run_cnt = 0. Samples are ignored.
- ARMED:
  - clk_enable and oow: if pn = 1 -> TRIPPED, else -> PENDING with run_cnt = 1.
  - In-window samples and cycles without clk_enable: stay.
  - arm is a no-op.
- PENDING:
  - clk_enable and oow: run_cnt + 1; when that equals pn -> TRIPPED.
  - clk_enable and in-window: run_cnt = 0 -> ARMED.
  - clk_enable low: hold all state (gaps do not break a run).
  - arm: no-op.
- Entry to TRIPPED: trip_o = 1; trip_val_o = triggering x_um_i; trip_cnt += 1, saturating at 2^CNT_W-1; run_cnt holds pn.
- TRIPPED: stays until clear. Further samples and arm are ignored; trip_val_o is frozen.
- If persist_n is lowered below run_cnt while PENDING, the next oow sample trips (compare is run_cnt+1 >= pn).

Decomposition:
- Shared package fa_pkg: DATA_W/CNT_W defaults and the state encoding constants ST_IDLE = 0, ST_ARMED = 1, ST_PENDING = 2, ST_TRIPPED = 3.
- One sub-module, fa_win_cmp: purely combinational signed window comparator (x, hi, lo -> oow). It is reusable for y-plane and other BPM channels.
- FSM, counters and capture stay in fa_um_intlk.

Test Plan:
- Reset, arm, then in-window samples 0, 500, 1000 with lo = -1000, hi = 1000 -> state ARMED, trip_o 0, run_cnt 0; boundary values ±1000 do not count.
- persist_n = 3, samples 1001, 1002, (clk_enable gap 5 cycles), 1003 -> state PENDING after 1001, trip_o = 1 one cycle after 1003 is presented, trip_val_o = 1003, trip_cnt = 1.
- persist_n = 3, samples 2000, 2000, 0, 2000 -> run_cnt 1, 2, 0, 1; no trip; state PENDING.
- persist_n = 0, one sample -5000 -> immediate trip, trip_val_o = -5000. Then clear and arm asserted together -> IDLE, trip_o 0, trip_val_o still -5000; arm next cycle -> ARMED.
- limit_lo = 10, limit_hi = -10, persist_n = 1, sample 0 -> trip. Force trip_cnt to 0xFFFF with repeated arm/trip/clear loops -> it stays 0xFFFF.
- Reset asserted while PENDING with run_cnt = 2 -> next cycle all outputs 0, state IDLE; samples are ignored until arm.
